// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : arb_pkg
// Brief  : Shared types, sizes and the request-vector rotate helper for the
//          eight-requester arbiter.
// Rev    : 1.0
// ============================================================================
package arb_pkg;

    localparam int N    = 8;
    localparam int ID_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    // Rotate left by amt positions: bit i of v lands on bit (i + amt) mod N.
    function automatic logic [N-1:0] rotl8(input logic [N-1:0] v,
                                           input logic [ID_W-1:0] amt);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[(i + int'(amt)) % N] = v[i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prio_enc8.sv
`default_nettype none
// ============================================================================
// Module : prio_enc8
// Brief  : Combinational 8-input priority encoder, highest set bit wins.
// Rev    : 1.0
// ============================================================================
module prio_enc8
    import arb_pkg::*;
(
    input  logic [N-1:0]    i_vec,
    output logic [ID_W-1:0] o_idx,
    output logic            o_vld
);

    always_comb begin
        o_idx = '0;
        o_vld = 1'b0;
        // Ascending scan so the last (highest) set bit overwrites lower ones.
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                o_idx = ID_W'(i);
                o_vld = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/req_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module : req_arbiter_8
// Brief  : Eight-requester arbiter, fixed or round-robin priority, registered
//          one-hot grant with bounded hold and a mandatory one-cycle gap.
// Rev    : 1.0
// ============================================================================
module req_arbiter_8 #(
    parameter int MAX_HOLD = 15,
    parameter int N        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                rr_mode,
    input  logic [N-1:0]        req,
    input  logic                done,
    output logic [N-1:0]        gnt,
    output logic [arb_pkg::ID_W-1:0] gnt_id,
    output logic                gnt_vld,
    output logic                idle
);
    import arb_pkg::*;

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] c_max_hold = HW'(MAX_HOLD);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [N-1:0]       r_gnt;
    logic [ID_W-1:0]    r_gnt_id;
    logic               r_gnt_vld;
    logic [ID_W-1:0]    r_ptr;
    logic [HW-1:0]      r_hold;

    logic [N-1:0]       w_gnt_nxt;
    logic [ID_W-1:0]    w_gnt_id_nxt;
    logic               w_gnt_vld_nxt;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [HW-1:0]      w_hold_nxt;

    logic [N-1:0]       w_enc_in;
    logic [ID_W-1:0]    w_enc_idx;
    logic               w_enc_vld;
    logic [ID_W-1:0]    w_win;
    logic               w_start;
    logic               w_release;

    // Round-robin rotates by -ptr so encoder bit j corresponds to req[(j+ptr)%8],
    // making ptr-1 the highest priority and ptr itself the lowest.
    assign w_enc_in = rr_mode ? rotl8(req, ID_W'(0) - r_ptr) : req;
    assign w_win    = rr_mode ? (w_enc_idx + r_ptr) : w_enc_idx;

    prio_enc8 u_prio_enc8 (
        .i_vec (w_enc_in),
        .o_idx (w_enc_idx),
        .o_vld (w_enc_vld)
    );

    assign w_start   = en && w_enc_vld;
    assign w_release = done || !req[r_gnt_id] || (r_hold == c_max_hold) || !en;

    // State register plus the registered grant datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_gnt_vld <= 1'b0;
            r_ptr     <= '0;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_gnt_vld <= w_gnt_vld_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold    <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start)   w_state_nxt = ST_GRANT;
            ST_GRANT: if (w_release) w_state_nxt = ST_GAP;
            ST_GAP:                  w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_gnt_vld_nxt = r_gnt_vld;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_gnt_nxt     = N'(1) << w_win;
                    w_gnt_id_nxt  = w_win;
                    w_gnt_vld_nxt = 1'b1;
                    w_hold_nxt    = HW'(1);
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_gnt_nxt     = '0;
                    w_gnt_vld_nxt = 1'b0;
                    w_ptr_nxt     = r_gnt_id;
                    w_hold_nxt    = '0;
                end else begin
                    w_hold_nxt    = r_hold + HW'(1);
                end
            end
            default: begin
                w_gnt_nxt     = '0;
                w_gnt_vld_nxt = 1'b0;
            end
        endcase
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign gnt_vld = r_gnt_vld;
    assign idle    = (r_state == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_req_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module : tb_req_arbiter_8
// Brief  : Directed self-checking bench for req_arbiter_8 (MAX_HOLD = 4).
// Rev    : 1.0
// ============================================================================
module tb_req_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       rr_mode;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       idle;

    int n_checks = 0;
    int n_errors = 0;

    req_arbiter_8 #(.MAX_HOLD(4), .N(8)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .rr_mode (rr_mode),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .idle    (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered when the next edge is an IDLE decision; done is pulsed on the
    // first grant cycle, leaving the FSM one edge before the next decision.
    task automatic grant_cycle(input string tag, input logic [2:0] exp_id);
        step();
        check({tag, "_id"},  32'(gnt_id), 32'(exp_id));
        check({tag, "_gnt"}, 32'(gnt), 32'(8'h01 << exp_id));
        done = 1'b1;
        step();
        check({tag, "_rel"}, 32'(gnt), 32'h0);
        done = 1'b0;
        step();
        check({tag, "_gap"}, 32'(gnt_vld), 32'h0);
        check({tag, "_idle"}, 32'(idle), 32'h1);
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        rr_mode = 1'b0;
        req     = 8'hFF;
        done    = 1'b0;

        // Reset held for three edges with all requests pending.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_gnt",  32'(gnt), 32'h0);
            check("rst_vld",  32'(gnt_vld), 32'h0);
            check("rst_id",   32'(gnt_id), 32'h0);
            check("rst_idle", 32'(idle), 32'h1);
        end
        rst_n = 1'b1;
        step();
        check("first_gnt", 32'(gnt), 32'h80);
        check("first_id",  32'(gnt_id), 32'h7);
        req = 8'h00;
        step();
        check("drop_rel", 32'(gnt), 32'h0);
        step();

        // Fixed priority: highest set bit wins, two idle cycles after done.
        req = 8'b0010_0100;
        step();
        check("fix_gnt", 32'(gnt), 32'h20);
        check("fix_id",  32'(gnt_id), 32'h5);
        done = 1'b1;
        step();
        check("fix_rel0", 32'(gnt), 32'h0);
        done = 1'b0;
        step();
        check("fix_rel1", 32'(gnt), 32'h0);
        step();
        check("fix_regnt", 32'(gnt), 32'h20);

        req = 8'h00;
        step();
        step();

        // Hold limit of 4: high 4, low 2, repeating.
        req = 8'h08;
        step();
        for (int i = 0; i < 12; i++) begin
            check("hold_vld", 32'(gnt_vld), ((i % 6) < 4) ? 32'h1 : 32'h0);
            if ((i % 6) < 4) check("hold_id", 32'(gnt_id), 32'h3);
            step();
        end
        check("hold_regnt", 32'(gnt), 32'h08);

        // Reset mid-grant: outputs clear immediately and ptr returns to 0.
        rst_n = 1'b0;
        step();
        check("mid_rst_gnt",  32'(gnt), 32'h0);
        check("mid_rst_idle", 32'(idle), 32'h1);
        check("mid_rst_id",   32'(gnt_id), 32'h0);
        rst_n   = 1'b1;
        rr_mode = 1'b1;
        req     = 8'h81;

        // Round-robin from ptr=0 alternates 7,0,7,0.
        grant_cycle("rr0", 3'd7);
        grant_cycle("rr1", 3'd0);
        grant_cycle("rr2", 3'd7);
        grant_cycle("rr3", 3'd0);

        // Same stimulus in fixed mode always picks 7.
        rr_mode = 1'b0;
        grant_cycle("fx0", 3'd7);
        grant_cycle("fx1", 3'd7);
        grant_cycle("fx2", 3'd7);

        // Enable drop during a grant to requester 2.
        req = 8'h04;
        step();
        check("en_gnt", 32'(gnt), 32'h04);
        check("en_id",  32'(gnt_id), 32'h2);
        step();
        check("en_hold", 32'(gnt), 32'h04);
        en = 1'b0;
        step();
        check("en_rel",     32'(gnt), 32'h0);
        check("en_gap_idle", 32'(idle), 32'h0);
        step();
        check("en_idle", 32'(idle), 32'h1);
        step();
        check("en_off_gnt",  32'(gnt_vld), 32'h0);
        check("en_off_idle", 32'(idle), 32'h1);
        en = 1'b1;
        step();
        check("en_regnt", 32'(gnt), 32'h04);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
